// File: rtl/maze_pkg.sv
// ---------------------------------------------------------------------------
// maze_pkg : shared constants and owner-state encoding for the maze memory
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package maze_pkg;

  localparam int ADDR_W     = 8;
  localparam int MAZE_CELLS = 256;

  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_OWN0 = 2'b01;
  localparam logic [1:0] ST_OWN1 = 2'b10;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick : two-input round-robin picker, one-hot result
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_pick (
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic [1:0] pick
);

  // On a tie the requester that was not served last wins.
  assign pick[0] = req[0] & (~req[1] | rr_last);
  assign pick[1] = req[1] & (~req[0] | ~rr_last);

endmodule

`default_nettype wire

// File: rtl/maze_mem_arbiter.sv
// ---------------------------------------------------------------------------
// maze_mem_arbiter : round-robin, burst-bounded sharing of the maze memory
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module maze_mem_arbiter
  import maze_pkg::*;
#(
  parameter int ADDR_W    = maze_pkg::ADDR_W,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_wr,
  input  logic [ADDR_W-1:0] r0_loc,
  input  logic              r0_din,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic              r0_rdata,
  input  logic              r1_req,
  input  logic              r1_wr,
  input  logic [ADDR_W-1:0] r1_loc,
  input  logic              r1_din,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic              r1_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_loc,
  output logic              mem_din,
  input  logic              mem_dout
);

  localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

  logic [1:0]        state_q, state_d;
  logic              rr_last_q, rr_last_d;
  logic [3:0]        burst_cnt_q, burst_cnt_d;
  logic              tag_valid_q, tag_valid_d;
  logic              tag_req_q, tag_req_d;
  logic [ADDR_W-1:0] mem_loc_q, mem_loc_d;

  logic [1:0]        req;
  logic [1:0]        pick;
  logic [1:0]        grant;
  logic              own;
  logic              any_gnt;
  logic              sel_wr;
  logic              sel_din;
  logic [ADDR_W-1:0] sel_loc;

  assign req = {r1_req, r0_req};

  rr_pick u_rr_pick (
    .req     (req),
    .rr_last (rr_last_q),
    .pick    (pick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_NONE;
      rr_last_q   <= 1'b1;
      burst_cnt_q <= 4'd0;
      tag_valid_q <= 1'b0;
      tag_req_q   <= 1'b0;
      mem_loc_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      burst_cnt_q <= burst_cnt_d;
      tag_valid_q <= tag_valid_d;
      tag_req_q   <= tag_req_d;
      mem_loc_q   <= mem_loc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    burst_cnt_d = burst_cnt_q;
    grant       = 2'b00;
    own         = (state_q == ST_OWN1);
    case (state_q)
      ST_NONE: begin
        if (|pick) begin
          grant       = pick;
          state_d     = pick[1] ? ST_OWN1 : ST_OWN0;
          burst_cnt_d = 4'd1;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (req[own] && (!req[~own] || burst_cnt_q < MAX_BURST_C)) begin
          grant[own]  = 1'b1;
          burst_cnt_d = (burst_cnt_q == 4'hF) ? burst_cnt_q : burst_cnt_q + 4'd1;
        end else if (req[~own]) begin
          // Either the burst budget is spent or the owner went idle.
          grant[~own] = 1'b1;
          state_d     = own ? ST_OWN0 : ST_OWN1;
          burst_cnt_d = 4'd1;
          rr_last_d   = own;
        end else begin
          state_d   = ST_NONE;
          rr_last_d = own;
        end
      end
      default: state_d = ST_NONE;
    endcase
  end

  always_comb begin
    any_gnt     = |grant;
    sel_wr      = grant[1] ? r1_wr  : r0_wr;
    sel_din     = grant[1] ? r1_din : r0_din;
    sel_loc     = grant[1] ? r1_loc : r0_loc;
    mem_loc_d   = any_gnt ? sel_loc : mem_loc_q;
    tag_valid_d = any_gnt & ~sel_wr;
    tag_req_d   = grant[1];

    // Port outputs are forced quiet while reset is asserted.
    r0_gnt    = rst & grant[0];
    r1_gnt    = rst & grant[1];
    mem_wr    = rst & any_gnt & sel_wr;
    mem_rd    = rst & any_gnt & ~sel_wr;
    mem_din   = rst & any_gnt & sel_din;
    mem_loc   = (rst & any_gnt) ? sel_loc : mem_loc_q;
    r0_rvalid = tag_valid_q & ~tag_req_q;
    r1_rvalid = tag_valid_q & tag_req_q;
    r0_rdata  = r0_rvalid & mem_dout;
    r1_rdata  = r1_rvalid & mem_dout;
  end

endmodule

`default_nettype wire
